// File: rtl/parallel_converter_n_to_1.sv
// N-to-1 lane converter: turns an N_LANES-wide bus of tagged blocks back into
// a serial stream, lane 0 (MSB field) first, one block per active slot.
module parallel_converter_n_to_1 #(
  parameter int NB_DATA_TAGGED = 67,
  parameter int N_LANES        = 20,
  parameter int NB_DATA_BUS    = NB_DATA_TAGGED * N_LANES
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_valid,
  input  logic                      i_bus_valid,
  input  logic [NB_DATA_BUS-1:0]    i_data,
  output logic                      o_load,
  output logic [NB_DATA_TAGGED-1:0] o_data,
  output logic                      o_valid,
  output logic                      o_frame_start
);

  localparam int NB_IDX = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_LANES - 1);
  localparam logic [NB_IDX-1:0] ONE_IDX  = NB_IDX'(1);

  logic [NB_IDX-1:0]         index_q, index_d;
  logic [NB_DATA_BUS-1:0]    shadow_q, shadow_d;
  logic                      shadow_valid_q, shadow_valid_d;
  logic [NB_DATA_TAGGED-1:0] o_data_q, o_data_d;
  logic                      o_valid_q, o_valid_d;
  logic                      o_frame_start_q, o_frame_start_d;

  logic                      active;
  logic                      idx_zero;
  logic [NB_DATA_TAGGED-1:0] in_lane0;
  logic [NB_DATA_TAGGED-1:0] sel_lane;
  logic                      sel_valid;
  logic [NB_DATA_TAGGED-1:0] shadow_lane [N_LANES];

  // Lane k sits at the k-th field counted down from the MSB.
  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    assign shadow_lane[k] = shadow_q[NB_DATA_BUS-1-k*NB_DATA_TAGGED -: NB_DATA_TAGGED];
  end

  assign in_lane0 = i_data[NB_DATA_BUS-1 -: NB_DATA_TAGGED];
  assign active   = i_enable && i_valid;
  assign idx_zero = (index_q == '0);

  // Lane 0 bypasses the shadow so the first block costs no extra slot.
  always_comb begin
    sel_lane  = shadow_lane[index_q];
    sel_valid = shadow_valid_q;
    if (idx_zero) begin
      sel_lane  = in_lane0;
      sel_valid = i_bus_valid;
    end
  end

  always_comb begin
    index_d         = index_q;
    shadow_d        = shadow_q;
    shadow_valid_d  = shadow_valid_q;
    o_data_d        = o_data_q;
    o_valid_d       = 1'b0;
    o_frame_start_d = 1'b0;
    if (active) begin
      index_d         = (index_q == LAST_IDX) ? '0 : index_q + ONE_IDX;
      o_data_d        = sel_lane;
      o_valid_d       = sel_valid;
      o_frame_start_d = idx_zero && sel_valid;
      if (idx_zero) begin
        shadow_d       = i_data;
        shadow_valid_d = i_bus_valid;
      end
    end
  end

  // ---- output / state register stage ----
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      index_q         <= '0;
      shadow_q        <= '0;
      shadow_valid_q  <= 1'b0;
      o_data_q        <= '0;
      o_valid_q       <= 1'b0;
      o_frame_start_q <= 1'b0;
    end else begin
      index_q         <= index_d;
      shadow_q        <= shadow_d;
      shadow_valid_q  <= shadow_valid_d;
      o_data_q        <= o_data_d;
      o_valid_q       <= o_valid_d;
      o_frame_start_q <= o_frame_start_d;
    end
  end

  assign o_load        = idx_zero;
  assign o_data        = o_data_q;
  assign o_valid       = o_valid_q;
  assign o_frame_start = o_frame_start_q;

endmodule

// File: doc/parallel_converter_n_to_1.md
Name: parallel_converter_n_to_1

Overview:
- Inverse companion of the 1-to-N lane converter. Takes an N_LANES-wide bus of 67-bit tagged blocks and re-serialises it into one tagged block per valid slot.
- Sits directly downstream of the 1-to-N converter. It consumes that converter's output bus, lane 0 first (lane 0 is the most significant field).
- Chaining 1-to-N followed by this block must reproduce the original serial stream, delayed by a fixed latency.

Parameters:
NB_DATA_TAGGED  67  width of one tagged block (66b coded block plus 1 tag bit)
N_LANES  20  number of blocks per bus word; must be >= 2
NB_DATA_BUS  NB_DATA_TAGGED*N_LANES  input bus width

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  global stage enable; low freezes all state
i_valid  in  1  slot strobe; one block is emitted per cycle with i_enable && i_valid
i_bus_valid  in  1  qualifies i_data at the capture slot
i_data  in  NB_DATA_BUS  bus word; lane k = i_data[NB_DATA_BUS-1-k*NB_DATA_TAGGED -: NB_DATA_TAGGED]
o_load  out  1  combinational; high while index==0, i.e. the bus is sampled on the next active slot
o_data  out  NB_DATA_TAGGED  registered serial block
o_valid  out  1  registered; o_data holds a block from a valid bus word
o_frame_start  out  1  registered; o_data holds lane 0 of a bus word

Behaviour:
- Reset (i_reset=1 at a clock edge) has priority over everything else. It sets:
  - index=0, shadow bus=0, shadow_valid=0
  - o_data=0, o_valid=0, o_frame_start=0
  - o_load therefore reads 1 after reset.
- Active slot means i_enable && i_valid at the clock edge. All state changes happen only on active slots or on reset.
- Index counter:
  - Width $clog2(N_LANES), counts 0..N_LANES-1.
  - Increments on each active slot.
  - Wraps from N_LANES-1 to 0 on an active slot. It never takes values >= N_LANES.
- Capture: on an active slot with index==0, shadow bus <= i_data and shadow_valid <= i_bus_valid. At all other times the shadow bus holds.
- Lane select on an active slot:
  - If index==0, the source is i_data lane 0 (bypass, so there is no extra slot of latency).
  - Otherwise the source is shadow lane[index].
- Output register on an active slot:
  - o_data <= selected lane.
  - o_valid <= (index==0 ? i_bus_valid : shadow_valid).
  - o_frame_start <= (index==0) && valid source.
- Non-active cycles (i_valid=0 or i_enable=0): o_data holds, o_valid<=0, o_frame_start<=0. The block emits nothing, and the counter and shadow do not move.
- Latency: one clock from the active slot that selects a lane to that lane appearing on o_data/o_valid.
- Lane order: lane 0 (MSB field) first, lane N_LANES-1 (LSB field) last.
- Invalid bus word (i_bus_valid=0 at capture): all N_LANES slots of that word emit o_valid=0, but the counter still advances so lane alignment is kept.
- Changes on i_data while index!=0 are ignored.
- Reset mid-word: the remaining lanes are discarded, and the next active slot captures a fresh bus.
- i_enable low mid-word: resumes at the same index with the same shadow contents. No lane is lost or duplicated.

Test Plan:
1. N_LANES=4, NB_DATA_TAGGED=8. Reset, then i_data=0x11223344, i_bus_valid=1, i_valid=1 continuously -> o_data 0x11,0x22,0x33,0x44 on consecutive cycles starting 1 cycle after the first slot; o_valid=1 throughout; o_frame_start=1 only with 0x11; o_load=1 on the cycles index==0.
2. Same config, i_valid toggling 1,0,1,0 -> each lane emitted once, one cycle after its slot; o_valid=0 on the gap cycles; order unchanged.
3. i_data changed to 0xAABBCCDD while index=2 -> remaining outputs 0x33,0x44, then 0xAA,0xBB,... after the wrap.
4. i_bus_valid=0 at the capture slot for one word -> four slots with o_valid=0 and no o_frame_start; the next word with i_bus_valid=1 emits normally with o_frame_start on its lane 0.
5. i_reset asserted while index=2 -> next cycle o_data=0, o_valid=0, o_load=1; the following active slot captures a new word and emits its lane 0. A separate case holds i_enable=0 for 5 cycles at index=1 -> no output and no movement; lane 1 is emitted after re-enable.
6. Default parameters, chained behind the 1-to-N converter and fed a 200-block random tagged stream -> the output stream equals the input stream, in order, with no drops or duplicates.
